motion_update_broadcast_scheduler: RTL and testbench

- Shares the single motion-update broadcast bus between NUM_REQ motion-update units using a round-robin arbiter.
- Serialises their updated particle records onto the bus that feeds every cell's double-buffered position/velocity cache.
- Sequences motion_update_enable around the broadcast, holds off for the caches' particle-count write and buffer swap, then reports completion.

---
 rtl/motion_update_broadcast_scheduler.sv | 177 +++++++++++++++++
 tb/tb_motion_update_broadcast_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_update_broadcast_scheduler.sv
// Round-robin scheduler that serialises motion-update records onto the
// shared cache broadcast bus and sequences enable, commit and done.
module motion_update_broadcast_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int NUM_REQ       = 4,
  parameter int COMMIT_CYCLES = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   req_dst_cell,
  input  logic [NUM_REQ-1:0]                   req_done,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]              out_data,
  output logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell,
  output logic                                 out_data_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic [CNT_WIDTH-1:0]                 particle_count,
  output logic                                 err_late
);

  localparam int REC_W = 3 * DATA_WIDTH;
  localparam int DST_W = 3 * CELL_ID_WIDTH;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CC_W  = $clog2(COMMIT_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BROADCAST,
    S_DRAIN,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t               state, state_n;
  logic [PTR_W-1:0]     ptr, ptr_n;
  logic [NUM_REQ-1:0]   done_flags, flags_n;
  logic [CC_W-1:0]      commit_cnt, commit_n;
  logic                 enable_n;
  logic [REC_W-1:0]     data_n;
  logic [DST_W-1:0]     dst_n;
  logic                 valid_n;
  logic                 busy_n;
  logic                 done_n;
  logic [CNT_WIDTH-1:0] count_n;
  logic                 err_n;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   flags_all;
  logic                 grant_any;
  logic [PTR_W-1:0]     grant_idx;

  assign eligible  = (state == S_BROADCAST) ? (req_valid & ~done_flags) : '0;
  assign flags_all = done_flags | req_done;
  assign req_ready = grant_any ? (ONE << grant_idx) : '0;

  // First eligible requester at or after the pointer, wrapping
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && eligible[(int'(ptr) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      ptr                  <= '0;
      done_flags           <= '0;
      commit_cnt           <= '0;
      motion_update_enable <= 1'b0;
      out_data             <= '0;
      out_data_dst_cell    <= '0;
      out_data_valid       <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      particle_count       <= '0;
      err_late             <= 1'b0;
    end else begin
      state                <= state_n;
      ptr                  <= ptr_n;
      done_flags           <= flags_n;
      commit_cnt           <= commit_n;
      motion_update_enable <= enable_n;
      out_data             <= data_n;
      out_data_dst_cell    <= dst_n;
      out_data_valid       <= valid_n;
      busy                 <= busy_n;
      done                 <= done_n;
      particle_count       <= count_n;
      err_late             <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    flags_n  = done_flags;
    commit_n = commit_cnt;
    enable_n = motion_update_enable;
    data_n   = out_data;
    dst_n    = out_data_dst_cell;
    valid_n  = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    count_n  = particle_count;
    err_n    = err_late;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_BROADCAST;
          flags_n  = '0;
          count_n  = '0;
          err_n    = 1'b0;
          enable_n = 1'b1;
          busy_n   = 1'b1;
        end
      end
      S_BROADCAST: begin
        enable_n = 1'b1;
        flags_n  = flags_all;
        if (|(req_valid & done_flags)) begin
          err_n = 1'b1;
        end
        if (grant_any) begin
          valid_n = 1'b1;
          data_n  = req_data[grant_idx*REC_W +: REC_W];
          dst_n   = req_dst_cell[grant_idx*DST_W +: DST_W];
          if (int'(grant_idx) == NUM_REQ - 1) begin
            ptr_n = '0;
          end else begin
            ptr_n = grant_idx + 1'b1;
          end
          if (particle_count != '1) begin
            count_n = particle_count + 1'b1;
          end
        end
        // A beat granted together with the last req_done is shown in DRAIN
        if (&flags_all) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_n  = S_COMMIT;
        enable_n = 1'b0;
        commit_n = '0;
      end
      S_COMMIT: begin
        if (commit_cnt == CC_W'(COMMIT_CYCLES - 1)) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          commit_n = commit_cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_motion_update_broadcast_scheduler.sv
// Bench for motion_update_broadcast_scheduler: table of whole rounds with
// hand-derived results, randomized rounds, and reset/restart corner cases.
`timescale 1ns/1ps
module tb_motion_update_broadcast_scheduler;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int NR   = 4;
  localparam int CC   = 3;
  localparam int CNTW = 16;
  localparam int RW   = 3 * DW;
  localparam int DSTW = 3 * CW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NR-1:0]        req_valid;
  logic [NR*RW-1:0]     req_data;
  logic [NR*DSTW-1:0]   req_dst_cell;
  logic [NR-1:0]        req_done;
  logic [NR-1:0]        req_ready;
  logic                 motion_update_enable;
  logic [RW-1:0]        out_data;
  logic [DSTW-1:0]      out_data_dst_cell;
  logic                 out_data_valid;
  logic                 busy;
  logic                 done;
  logic [CNTW-1:0]      particle_count;
  logic                 err_late;

  motion_update_broadcast_scheduler #(
    .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .NUM_REQ(NR),
    .COMMIT_CYCLES(CC), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .req_valid(req_valid), .req_data(req_data),
    .req_dst_cell(req_dst_cell), .req_done(req_done),
    .req_ready(req_ready),
    .motion_update_enable(motion_update_enable),
    .out_data(out_data), .out_data_dst_cell(out_data_dst_cell),
    .out_data_valid(out_data_valid), .busy(busy), .done(done),
    .particle_count(particle_count), .err_late(err_late)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [NR-1:0][3:0] cnt;
    logic [NR-1:0]      late;
    logic               restart;
    logic [15:0]        exp_count;
    logic [7:0]         exp_lat;
    logic               exp_err;
  } row_t;

  row_t rows [5];

  // Reference model state: pointer persists across rounds, cleared by rst
  int            m_ptr;
  logic [NR-1:0] m_flag;
  int            m_cnt;
  bit            m_err;
  logic [RW-1:0]   rec_data [NR][8];
  logic [DSTW-1:0] rec_dst  [NR][8];
  int rem [NR];
  int tot [NR];

  task automatic idle_inputs();
    start        = 1'b0;
    req_valid    = '0;
    req_done     = '0;
    req_data     = '0;
    req_dst_cell = '0;
  endtask

  task automatic run_round(input logic [NR-1:0][3:0] cnt,
                           input logic [NR-1:0] late,
                           input bit rnd, input bit restart,
                           input int abort_at, input int exp_count,
                           input int exp_lat, input int exp_err);
    bit              exp_v;
    logic [RW-1:0]   exp_d;
    logic [DSTW-1:0] exp_dst;
    logic [NR-1:0]   v, d;
    int              g, t, sum;
    bit              finished;
    sum   = 0;
    exp_v = 0;
    exp_d = '0;
    exp_dst = '0;
    for (int i = 0; i < NR; i++) begin
      tot[i] = int'(cnt[i]);
      rem[i] = tot[i];
      sum += tot[i];
      for (int k = 0; k < 8; k++) begin
        rec_data[i][k] = {$urandom, $urandom, $urandom};
        rec_dst[i][k]  = rnd ? DSTW'($urandom) : 12'h424;
      end
    end
    if (exp_count < 0) exp_count = sum;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    t      = 1;
    m_flag = '0;
    m_cnt  = 0;
    m_err  = 0;
    chk("start_count_clear", particle_count, 0);
    chk("start_err_clear", err_late, 0);
    finished = 0;
    while (!finished) begin
      chk("bc_enable", motion_update_enable, 1);
      chk("bc_busy", busy, 1);
      chk("bc_valid", out_data_valid, exp_v);
      if (exp_v) begin
        chk("bc_data", out_data, exp_d);
        chk("bc_dst", out_data_dst_cell, exp_dst);
      end
      if (abort_at > 0 && m_cnt == abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_enable", motion_update_enable, 0);
        chk("rst_valid", out_data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", particle_count, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", req_ready, 0);
        idle_inputs();
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      for (int i = 0; i < NR; i++) begin
        v[i] = (rem[i] > 0 && (!rnd || $urandom_range(0, 3) != 0))
               || (late[i] && m_flag[i]);
        req_data[i*RW +: RW]         = rec_data[i][tot[i]-rem[i]];
        req_dst_cell[i*DSTW +: DSTW] = rec_dst[i][tot[i]-rem[i]];
      end
      req_valid = v;
      req_done  = '0;
      #1;
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (g < 0 && v[j] && !m_flag[j]) g = j;
      end
      chk("req_ready", req_ready, (g >= 0) ? (NR'(1) << g) : NR'(0));
      for (int i = 0; i < NR; i++) if (v[i] && m_flag[i]) m_err = 1;
      exp_v = (g >= 0);
      if (g >= 0) begin
        exp_d   = rec_data[g][tot[g]-rem[g]];
        exp_dst = rec_dst[g][tot[g]-rem[g]];
        rem[g]--;
        m_cnt++;
        m_ptr = (g + 1) % NR;
      end
      for (int i = 0; i < NR; i++)
        d[i] = !m_flag[i] && rem[i] == 0
               && (!rnd || i == g || $urandom_range(0, 2) == 0);
      if (t > 150) d = ~m_flag;
      req_done = d;
      m_flag   = m_flag | d;
      finished = &m_flag;
      @(negedge clk);
      t++;
    end
    req_valid = '1;
    req_done  = '0;
    chk("drain_enable", motion_update_enable, 1);
    chk("drain_valid", out_data_valid, exp_v);
    if (exp_v) chk("drain_data", out_data, exp_d);
    #1 chk("drain_ready", req_ready, 0);
    for (int c = 0; c < CC; c++) begin
      @(negedge clk);
      t++;
      start = (restart && c == 0);
      chk("commit_enable", motion_update_enable, 0);
      chk("commit_valid", out_data_valid, 0);
      chk("commit_done", done, 0);
      chk("commit_busy", busy, 1);
      #1 chk("commit_ready", req_ready, 0);
    end
    @(negedge clk);
    t++;
    start     = 1'b0;
    req_valid = '0;
    chk("done_pulse", done, 1);
    chk("done_count", particle_count, exp_count);
    chk("done_err", err_late, (exp_err < 0) ? m_err : exp_err[0]);
    if (exp_lat >= 0) chk("done_latency", t, exp_lat);
    repeat (3) begin
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_enable", motion_update_enable, 0);
    end
    chk("count_hold", particle_count, exp_count);
  endtask

  initial begin
    rows[0] = '{cnt: {4'd1, 4'd1, 4'd1, 4'd1}, late: 4'b0000, restart: 1'b0,
                exp_count: 16'd4, exp_lat: 8'd9, exp_err: 1'b0};
    rows[1] = '{cnt: {4'd6, 4'd0, 4'd6, 4'd0}, late: 4'b0000, restart: 1'b0,
                exp_count: 16'd12, exp_lat: 8'd17, exp_err: 1'b0};
    rows[2] = '{cnt: {4'd0, 4'd0, 4'd0, 4'd0}, late: 4'b0000, restart: 1'b0,
                exp_count: 16'd0, exp_lat: 8'd6, exp_err: 1'b0};
    rows[3] = '{cnt: {4'd3, 4'd0, 4'd2, 4'd3}, late: 4'b0100, restart: 1'b0,
                exp_count: 16'd8, exp_lat: 8'd13, exp_err: 1'b1};
    rows[4] = '{cnt: {4'd1, 4'd5, 4'd0, 4'd2}, late: 4'b0000, restart: 1'b1,
                exp_count: 16'd8, exp_lat: 8'd13, exp_err: 1'b0};

    rst = 1'b1;
    idle_inputs();
    m_ptr = 0;
    @(negedge clk);
    chk("reset_enable", motion_update_enable, 0);
    chk("reset_valid", out_data_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", particle_count, 0);
    chk("reset_err", err_late, 0);
    chk("reset_data", out_data, 0);
    chk("reset_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 5; r++)
      run_round(rows[r].cnt, rows[r].late, 1'b0, rows[r].restart, 0,
                int'(rows[r].exp_count), int'(rows[r].exp_lat),
                int'(rows[r].exp_err));

    run_round({4'd5, 4'd5, 4'd5, 4'd5}, '0, 1'b0, 1'b0, 3, -1, -1, -1);
    run_round(rows[0].cnt, '0, 1'b0, 1'b0, 0, 4, 9, 0);

    for (int r = 0; r < 20; r++) begin
      logic [NR-1:0][3:0] rc;
      logic [NR-1:0]      rl;
      for (int i = 0; i < NR; i++) rc[i] = 4'($urandom_range(0, 6));
      rl = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
      run_round(rc, rl, 1'b1, 1'b0, 0, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
